seq_generator_case: RTL

- Serial pattern transmitter: the driving end of the bit stream consumed by the sequence detectors.
- On a start request it shifts a fixed SEQ pattern out MSB-first on data_out, one bit per clock.
- Repeats the pattern num_reps times, with optional idle gaps between repetitions.
- Used as stimulus source and as the reference transmitter in generator-to-detector formal and simulation harnesses.

---
 rtl/seq_pkg.sv | 20 ++
 rtl/seq_generator_case_if.sv | 25 ++
 rtl/seq_generator_case.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared constants and types for the serial pattern generator and the
// sequence detectors that consume its bit stream.
package seq_pkg;

    // Reference pattern, transmitted MSB first, and its length.
    localparam int                         SEQ_LEN_DEFAULT = 7;
    localparam logic [SEQ_LEN_DEFAULT-1:0] SEQ_DEFAULT     = 7'b1010011;

    // Default idle spacing between repetitions and width of the repetition count.
    localparam int GAP_LEN_DEFAULT = 2;
    localparam int REP_W_DEFAULT   = 4;

    // Generator control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } gen_state_t;

endpackage

// File: rtl/seq_generator_case_if.sv
// Control and serial-stream bundle of the pattern generator. The master side
// requests bursts; the slave side (the generator) returns the bit stream.
interface seq_generator_case_if
    import seq_pkg::*;
#(
    parameter int REP_W = REP_W_DEFAULT
);
    logic             start;
    logic [REP_W-1:0] num_reps;
    logic             abort;
    logic             data_out;
    logic             data_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, num_reps, abort,
        input  data_out, data_valid, busy, done
    );

    modport slave (
        input  start, num_reps, abort,
        output data_out, data_valid, busy, done
    );
endinterface

// File: rtl/seq_generator_case.sv
// Serial pattern transmitter: on start, shifts SEQ out MSB first num_reps
// times, separated by GAP_LEN idle cycles, then pulses done. All outputs are
// registered, so each one is computed for the coming cycle alongside the
// next state.
module seq_generator_case
    import seq_pkg::*;
#(
    parameter int                 SEQ_LEN = SEQ_LEN_DEFAULT,
    parameter logic [SEQ_LEN-1:0] SEQ     = SEQ_DEFAULT,
    parameter int                 GAP_LEN = GAP_LEN_DEFAULT,
    parameter int                 REP_W   = REP_W_DEFAULT
)(
    input  logic               clk,
    input  logic               rst_n,
    seq_generator_case_if.slave bus
);

    localparam int IDX_W = $clog2(SEQ_LEN);
    // A zero-length gap never uses the gap counter, but it still needs one bit.
    localparam int GAP_W = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_LEN);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    gen_state_t       state, state_nxt;
    logic [IDX_W-1:0] bit_idx, bit_idx_nxt, bit_idx_dec;
    logic [REP_W-1:0] reps_left, reps_left_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;

    logic data_out_q,   data_out_nxt;
    logic data_valid_q, data_valid_nxt;
    logic busy_q,       busy_nxt;
    logic done_q,       done_nxt;

    assign bit_idx_dec = bit_idx - 1'b1;

    // Next state, counter updates and the output values for the next cycle.
    always_comb begin
        state_nxt      = state;
        bit_idx_nxt    = bit_idx;
        reps_left_nxt  = reps_left;
        gap_cnt_nxt    = gap_cnt;
        data_out_nxt   = 1'b0;
        data_valid_nxt = 1'b0;
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;

        case (state)
            IDLE: begin
                // abort beats start; a zero repetition count is not a burst
                if (bus.start && (bus.num_reps != '0) && !bus.abort) begin
                    state_nxt      = SEND;
                    bit_idx_nxt    = IDX_LAST;
                    reps_left_nxt  = bus.num_reps;
                    data_out_nxt   = SEQ[IDX_LAST];
                    data_valid_nxt = 1'b1;
                    busy_nxt       = 1'b1;
                end
            end

            SEND: begin
                if (bus.abort) begin
                    state_nxt     = IDLE;
                    bit_idx_nxt   = '0;
                    reps_left_nxt = '0;
                    gap_cnt_nxt   = '0;
                end else if (bit_idx == '0) begin
                    if (reps_left == REP_ONE) begin
                        state_nxt     = IDLE;
                        reps_left_nxt = '0;
                        done_nxt      = 1'b1;
                    end else begin
                        reps_left_nxt = reps_left - 1'b1;
                        if (GAP_LEN == 0) begin
                            bit_idx_nxt    = IDX_LAST;
                            data_out_nxt   = SEQ[IDX_LAST];
                            data_valid_nxt = 1'b1;
                            busy_nxt       = 1'b1;
                        end else begin
                            state_nxt   = GAP;
                            gap_cnt_nxt = GAP_INIT;
                            busy_nxt    = 1'b1;
                        end
                    end
                end else begin
                    bit_idx_nxt    = bit_idx_dec;
                    data_out_nxt   = SEQ[bit_idx_dec];
                    data_valid_nxt = 1'b1;
                    busy_nxt       = 1'b1;
                end
            end

            GAP: begin
                // gap_cnt counts the idle cycles still to show, including this one
                if (bus.abort) begin
                    state_nxt     = IDLE;
                    bit_idx_nxt   = '0;
                    reps_left_nxt = '0;
                    gap_cnt_nxt   = '0;
                end else if (gap_cnt == GAP_ONE) begin
                    state_nxt      = SEND;
                    gap_cnt_nxt    = '0;
                    bit_idx_nxt    = IDX_LAST;
                    data_out_nxt   = SEQ[IDX_LAST];
                    data_valid_nxt = 1'b1;
                    busy_nxt       = 1'b1;
                end else begin
                    gap_cnt_nxt = gap_cnt - 1'b1;
                    busy_nxt    = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_idx      <= '0;
            reps_left    <= '0;
            gap_cnt      <= '0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            bit_idx      <= bit_idx_nxt;
            reps_left    <= reps_left_nxt;
            gap_cnt      <= gap_cnt_nxt;
            data_out_q   <= data_out_nxt;
            data_valid_q <= data_valid_nxt;
            busy_q       <= busy_nxt;
            done_q       <= done_nxt;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

`ifdef FORMAL
    // Output consistency: done only outside a burst, valid bits only inside one.
    always_comb begin
        if (done_q)       assert (!busy_q);
        if (data_valid_q) assert (busy_q);
    end

    localparam int BURST2 = 2 * SEQ_LEN + GAP_LEN;

    cover property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE && bus.start && bus.num_reps == REP_W'(2) && !bus.abort)
        ##1 (!bus.abort) [*BURST2] ##1 done_q);
`endif

endmodule
